forwarding_scoreboard: RTL and testbench
========================================

Name: forwarding_scoreboard

Overview:
- Parametrised successor to the combinational EX-stage forwarding unit.
- Keeps its own shift-register record of in-flight destination registers for FWD_DEPTH post-EX stages (stage 1 = MEM, stage 2 = WB, ...).
- Detects load-use hazards and raises stall for the instruction in ID.
- Pre-computes that instruction's operand forward selects one cycle early and presents them registered during its EX cycle, removing the comparators from the EX critical path.

Parameters:
REG_BITS, 5, register index width
NUM_SRC, 2, source operands per instruction
FWD_DEPTH, 2, number of tracked post-EX stages that can forward (>=1)
LOAD_LAT, 2, first stage index holding load data; range 1..FWD_DEPTH
ZERO_REG, 31, hard-wired zero register index; never forwarded or stalled on
CNT_W, 16, stall counter width
(derived) SEL_W = $clog2(FWD_DEPTH+1)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous reset, active low
ex_valid  input  1  EX stage holds a real instruction (0 = bubble)
ex_regwrite  input  1  EX instruction writes a register
ex_is_load  input  1  EX instruction is a load
ex_rd  input  REG_BITS  EX destination register
id_valid  input  1  ID stage holds a real instruction
id_src  input  NUM_SRC*REG_BITS  ID source registers, operand s at [s*REG_BITS +: REG_BITS]
id_src_used  input  NUM_SRC  per-operand "operand is read" mask
stall  output  1  combinational; hold PC/IF/ID and inject an EX bubble
fwd_sel  output  NUM_SRC*SEL_W  registered; per-operand select for the instruction now in EX; 0 = register file, k = stage k
stall_count  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (reset_n low, asynchronous): all stage valid bits 0, fwd_sel 0, stall_count 0. stall is then 0, since it is combinational from cleared state and inputs.
- Entry e0 is the live EX instruction. e0 match-eligible = ex_valid & ex_regwrite.
- Stage shift, every rising edge, unconditional:
  - stage1 <= {ex_valid & ex_regwrite, ex_rd, ex_is_load}.
  - stage k+1 <= stage k.
  - stage FWD_DEPTH drops out (already written to regfile, write-before-read).
- Match, per operand s against entry x (e0 or stage j):
  - x valid, x.rd == id_src[s], x.rd != ZERO_REG, id_src_used[s].
- Youngest match wins. Priority order: e0, then stage1 ... stage FWD_DEPTH-1. Stage FWD_DEPTH is never a forward source for ID.
- Next-cycle position of the winner: e0 -> 1; stage j -> j+1.
- Stall:
  - stall = id_valid & any s whose winner is a load and whose next position < LOAD_LAT.
  - An older load match shadowed by a younger non-load match does not stall.
- fwd_sel register, rising edge:
  - If id_valid & ~stall: fwd_sel[s] <= winner next position, or 0 if no match.
  - Otherwise fwd_sel <= 0 (EX receives a bubble).
- Latency: stall is 0-cycle (combinational). fwd_sel is valid 1 cycle after the ID evaluation, aligned with that instruction's EX cycle.
- stall_count: +1 on each edge where stall=1; holds at 2^CNT_W-1.
- Both operands may match different or identical entries independently; each uses its own winner.
- After a stall the pipeline drives ex_valid=0 on the next cycle. The block relies on this and does not insert the bubble itself.
- Reset asserted mid-stream: all tracking is lost immediately. The first post-reset instruction sees no forwards and no stalls.

Test Plan:
1. Hold reset_n=0 with ex_valid=1 and id_valid=1 driven -> fwd_sel=0, stall=0, stall_count=0. Release reset_n -> normal operation from the next edge.
2. EX: ALU writes x5; ID: src0=x5 used -> stall=0, next cycle fwd_sel[0]=1. Following cycle ID src1=x5 (x5 now in stage1) -> next cycle fwd_sel[1]=2.
3. Defaults (LOAD_LAT=2): EX load x7; ID src0=x7 used -> stall=1, fwd_sel<=0, stall_count=1. Next cycle ex_valid=0 and load in stage1 -> stall=0, fwd_sel[0]=2 one cycle later.
4. EX writes x31 with ID src0=x31; separately EX writes x4 with ID src1=x4 but id_src_used[1]=0 -> stall=0, fwd_sel=0 in both cases.
5. stage1 holds load x3, EX ALU writes x3, ID src0=src1=x3 -> stall=0, fwd_sel[0]=fwd_sel[1]=1.
6. FWD_DEPTH=3, LOAD_LAT=3: load x9 in stage1, ID reads x9 -> stall=1. Next cycle (load in stage2) -> stall=0, fwd_sel=3. Force stall_count near max -> holds at all-ones.

Source files
------------

// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destinations for FWD_DEPTH post-EX stages,
// raises load-use stalls for ID and registers the ID instruction's forward selects for its EX cycle.
module forwarding_scoreboard #(
  parameter int REG_BITS  = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 2,
  parameter int ZERO_REG  = 31,
  parameter int CNT_W     = 16,
  localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ex_valid,
  input  logic                         ex_regwrite,
  input  logic                         ex_is_load,
  input  logic [REG_BITS-1:0]          ex_rd,
  input  logic                         id_valid,
  input  logic [NUM_SRC*REG_BITS-1:0]  id_src,
  input  logic [NUM_SRC-1:0]           id_src_used,
  output logic                         stall,
  output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
  output logic [CNT_W-1:0]             stall_count
);

  localparam logic [REG_BITS-1:0] ZERO_IDX = REG_BITS'(ZERO_REG);

  logic [FWD_DEPTH-1:0]     stg_vld_q;
  logic [FWD_DEPTH-1:0]     stg_ld_q;
  logic [REG_BITS-1:0]      stg_rd_q [FWD_DEPTH];
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q, fwd_sel_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_SRC-1:0]       hzd;
  logic [REG_BITS-1:0]      src_w;
  logic [SEL_W-1:0]         pos_w;
  logic                     ld_w;

  // Winner search runs oldest-to-youngest so the youngest match overrides.
  always_comb begin
    fwd_sel_d = '0;
    hzd       = '0;
    src_w     = '0;
    pos_w     = '0;
    ld_w      = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_w = id_src[s*REG_BITS +: REG_BITS];
      pos_w = '0;
      ld_w  = 1'b0;
      for (int j = FWD_DEPTH - 1; j >= 1; j--) begin
        if (stg_vld_q[j-1] && (stg_rd_q[j-1] == src_w)) begin
          pos_w = SEL_W'(j + 1);
          ld_w  = stg_ld_q[j-1];
        end
      end
      if (ex_valid && ex_regwrite && (ex_rd == src_w)) begin
        pos_w = SEL_W'(1);
        ld_w  = ex_is_load;
      end
      if (!id_src_used[s] || (src_w == ZERO_IDX)) begin
        pos_w = '0;
      end
      hzd[s] = (pos_w != '0) && ld_w && (int'(pos_w) < LOAD_LAT);
      fwd_sel_d[s*SEL_W +: SEL_W] = pos_w;
    end
  end

  // Gating with reset_n keeps stall low while tracking state is held clear.
  assign stall = reset_n & id_valid & (|hzd);
  assign cnt_d = (stall && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_vld_q <= '0;
      fwd_sel_q <= '0;
      cnt_q     <= '0;
    end else begin
      stg_vld_q[0] <= ex_valid & ex_regwrite;
      for (int j = 1; j < FWD_DEPTH; j++) begin
        stg_vld_q[j] <= stg_vld_q[j-1];
      end
      fwd_sel_q <= (id_valid && !stall) ? fwd_sel_d : '0;
      cnt_q     <= cnt_d;
    end
  end

  // Destination/load tags are qualified by stg_vld_q and need no reset.
  always_ff @(posedge clk) begin
    stg_rd_q[0] <= ex_rd;
    stg_ld_q[0] <= ex_is_load;
    for (int j = 1; j < FWD_DEPTH; j++) begin
      stg_rd_q[j] <= stg_rd_q[j-1];
      stg_ld_q[j] <= stg_ld_q[j-1];
    end
  end

  assign fwd_sel     = fwd_sel_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Scoreboard bench for forwarding_scoreboard: two configurations share stimulus,
// an age-history reference model queues per-cycle expectations for a negedge monitor.
module tb_forwarding_scoreboard;

  logic       clk;
  logic       reset_n;
  logic       ex_valid, ex_regwrite, ex_is_load;
  logic [4:0] ex_rd;
  logic       id_valid;
  logic [9:0] id_src;
  logic [1:0] id_src_used;

  logic        stall_a, stall_b;
  logic [3:0]  fwd_sel_a, fwd_sel_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;

  forwarding_scoreboard u_dut_a (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .stall(stall_a), .fwd_sel(fwd_sel_a), .stall_count(cnt_a)
  );

  forwarding_scoreboard #(.FWD_DEPTH(3), .LOAD_LAT(3), .CNT_W(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .stall(stall_b), .fwd_sel(fwd_sel_b), .stall_count(cnt_b)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } ent_t;

  typedef struct packed {
    logic        st_a;
    logic [3:0]  sel_a;
    logic [15:0] cnt_a;
    logic        st_b;
    logic [3:0]  sel_b;
    logic [2:0]  cnt_b;
  } rec_t;

  rec_t exp_q[$];
  ent_t hist_a[$];
  ent_t hist_b[$];
  logic [3:0]  msel_a, msel_b;
  logic [15:0] mcnt_a;
  logic [2:0]  mcnt_b;
  logic        prev_stall;
  int          n_chk;
  int          n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: entry of age a is the EX instruction seen a cycles ago (age 0 = live EX).
  // Youngest matching age below depth wins; its next-cycle position is age+1.
  function automatic void model_eval(input ent_t cur, input ent_t h[$], input int depth,
                                     input int llat, input logic [4:0] s0, input logic [4:0] s1,
                                     input logic [1:0] used, input logic idv,
                                     output logic st, output logic [3:0] nsel);
    st   = 1'b0;
    nsel = 4'd0;
    for (int s = 0; s < 2; s++) begin
      logic [4:0] src;
      int   pos;
      logic ld;
      ent_t e;
      src = (s == 0) ? s0 : s1;
      pos = 0;
      ld  = 1'b0;
      if (used[s] && src != 5'd31) begin
        for (int a = 0; a < depth; a++) begin
          if (a == 0) e = cur;
          else if (a - 1 < h.size()) e = h[a-1];
          else e = '0;
          if (e.v && e.rd == src) begin
            pos = a + 1;
            ld  = e.ld;
            break;
          end
        end
      end
      if (pos != 0 && ld && pos < llat) st = 1'b1;
      nsel[s*2 +: 2] = 2'(pos);
    end
    st = st & idv;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic cyc(input logic rn, input logic exv, input logic exw, input logic exl,
                     input logic [4:0] exrd, input logic idv, input logic [4:0] s0,
                     input logic [4:0] s1, input logic [1:0] used);
    ent_t cur;
    logic st_a, st_b;
    logic [3:0] ns_a, ns_b;
    rec_t r;
    @(posedge clk);
    #1;
    reset_n     = rn;
    ex_valid    = exv;
    ex_regwrite = exw;
    ex_is_load  = exl;
    ex_rd       = exrd;
    id_valid    = idv;
    id_src      = {s1, s0};
    id_src_used = used;
    cur.v  = exv & exw;
    cur.rd = exrd;
    cur.ld = exl;
    if (!rn) begin
      hist_a.delete();
      hist_b.delete();
      msel_a = '0; msel_b = '0; mcnt_a = '0; mcnt_b = '0;
      st_a = 1'b0; st_b = 1'b0; ns_a = '0; ns_b = '0;
    end else begin
      model_eval(cur, hist_a, 2, 2, s0, s1, used, idv, st_a, ns_a);
      model_eval(cur, hist_b, 3, 3, s0, s1, used, idv, st_b, ns_b);
    end
    r.st_a = st_a; r.sel_a = msel_a; r.cnt_a = mcnt_a;
    r.st_b = st_b; r.sel_b = msel_b; r.cnt_b = mcnt_b;
    exp_q.push_back(r);
    prev_stall = st_a | st_b;
    if (rn) begin
      msel_a = (idv && !st_a) ? ns_a : 4'd0;
      msel_b = (idv && !st_b) ? ns_b : 4'd0;
      if (st_a && mcnt_a != 16'hFFFF) mcnt_a = mcnt_a + 16'd1;
      if (st_b && mcnt_b != 3'd7) mcnt_b = mcnt_b + 3'd1;
      hist_a.push_front(cur);
      hist_b.push_front(cur);
      if (hist_a.size() > 4) void'(hist_a.pop_back());
      if (hist_b.size() > 4) void'(hist_b.pop_back());
    end
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00);
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("stall_a",   32'(stall_a),   32'(r.st_a));
      chk("fwd_sel_a", 32'(fwd_sel_a), 32'(r.sel_a));
      chk("count_a",   32'(cnt_a),     32'(r.cnt_a));
      chk("stall_b",   32'(stall_b),   32'(r.st_b));
      chk("fwd_sel_b", 32'(fwd_sel_b), 32'(r.sel_b));
      chk("count_b",   32'(cnt_b),     32'(r.cnt_b));
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; prev_stall = 1'b0;
    msel_a = '0; msel_b = '0; mcnt_a = '0; mcnt_b = '0;
    reset_n = 1'b0; ex_valid = 1'b0; ex_regwrite = 1'b0; ex_is_load = 1'b0;
    ex_rd = '0; id_valid = 1'b0; id_src = '0; id_src_used = '0;

    // Reset held with a live matching load in EX and a reader in ID.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 2'b11);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 2'b11);
    idle();
    // ALU x5 forwarded from stage 1, then stage 2.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 5'd0, 2'b01);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd5, 2'b10);
    idle();
    // Load-use on x7: stall, bubble, then forward.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 5'd0, 2'b01);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 5'd0, 2'b01);
    idle();
    // Zero register and unused operand never match.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 1'b1, 5'd31, 5'd0, 2'b01);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 5'd0, 5'd4, 2'b01);
    idle();
    idle();
    // Older load x3 shadowed by a younger ALU write of x3.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 5'd3, 2'b11);
    idle();
    // Repeated load-use on x9 saturates the narrow counter.
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 2'b00);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 5'd9, 2'b11);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 5'd0, 2'b01);
      idle();
    end

    for (int i = 0; i < 600; i++) begin
      logic [4:0] regs [5];
      logic rn, exv;
      regs[0] = 5'd3; regs[1] = 5'd4; regs[2] = 5'd5; regs[3] = 5'd7; regs[4] = 5'd31;
      rn  = !(i >= 300 && i < 302);
      exv = prev_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      cyc(rn, exv, ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) < 4),
          regs[$urandom_range(0, 4)], ($urandom_range(0, 4) != 0),
          regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)], 2'($urandom_range(0, 3)));
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
